// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the pipeline-status inputs and the pipe-control outputs of the
// hazard/stall controller.
//   master : pipeline datapath side (drives ID/EXE/MEM status, receives controls)
//   slave  : hazard controller side (receives status, drives controls)
// Status  : id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_branch_taken,
//           exe_rf_we, exe_rf_waddr, exe_is_load, exe_is_mdu,
//           mem_rf_we, mem_rf_waddr
// Control : pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exe_kill,
//           mdu_start, fwd_a_sel, fwd_b_sel, stall_cycles
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        id_branch_taken;
   logic        exe_rf_we;
   logic [4:0]  exe_rf_waddr;
   logic        exe_is_load;
   logic        exe_is_mdu;
   logic        mem_rf_we;
   logic [4:0]  mem_rf_waddr;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_we;
   logic        idex_flush;
   logic        exe_kill;
   logic        mdu_start;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic [31:0] stall_cycles;

   modport master (
      output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_branch_taken,
             exe_rf_we, exe_rf_waddr, exe_is_load, exe_is_mdu,
             mem_rf_we, mem_rf_waddr,
      input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exe_kill,
             mdu_start, fwd_a_sel, fwd_b_sel, stall_cycles
   );

   modport slave (
      input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_branch_taken,
             exe_rf_we, exe_rf_waddr, exe_is_load, exe_is_mdu,
             mem_rf_we, mem_rf_waddr,
      output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exe_kill,
             mdu_start, fwd_a_sel, fwd_b_sel, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing/stall controller of the 5-stage pipeline. Generates PC, IF/ID and
// ID/EXE write-enables and bubble controls, selects EXE operand forwarding,
// holds the pipe while the multi-cycle MUL/DIV unit runs and keeps a
// saturating count of stalled (pc_we=0) cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - pipe_hazard_ctrl_if.slave (status in, pipe controls out)
// Parameters:
//   MDU_LATENCY - EXE cycles occupied by a MUL/DIV (>=2)
//   DELAY_SLOT  - 1: taken branch keeps the delay slot; 0: squash IF/ID
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_LATENCY = 32,
   parameter bit          DELAY_SLOT  = 1'b1
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(MDU_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      stall_cycles_r;

   logic rs_exe_s, rt_exe_s, rs_mem_s, rt_mem_s;
   logic mdu_start_s, mdu_stall_s, load_use_s;
   logic pc_we_s, ifid_we_s, ifid_flush_s, idex_we_s, idex_flush_s, exe_kill_s;
   logic [1:0] fwd_a_s, fwd_b_s;

   // Register $0 is hardwired to zero, so it never creates a dependency.
   assign rs_exe_s = bus.id_uses_rs && (bus.id_rs_addr != 5'd0) && bus.exe_rf_we
                     && (bus.exe_rf_waddr == bus.id_rs_addr);
   assign rt_exe_s = bus.id_uses_rt && (bus.id_rt_addr != 5'd0) && bus.exe_rf_we
                     && (bus.exe_rf_waddr == bus.id_rt_addr);
   assign rs_mem_s = bus.id_uses_rs && (bus.id_rs_addr != 5'd0) && bus.mem_rf_we
                     && (bus.mem_rf_waddr == bus.id_rs_addr);
   assign rt_mem_s = bus.id_uses_rt && (bus.id_rt_addr != 5'd0) && bus.mem_rf_we
                     && (bus.mem_rf_waddr == bus.id_rt_addr);

   // Everything is qualified with reset so the pipe runs freely while held in
   // reset, and a MUL/DIV still sitting in EXE cannot start the unit then.
   assign mdu_start_s = reset && (state_r == ST_IDLE) && bus.exe_is_mdu;
   assign mdu_stall_s = mdu_start_s || (reset && (state_r == ST_BUSY));
   assign load_use_s  = reset && bus.exe_is_load && (rs_exe_s || rt_exe_s);

   // Operand forwarding: EXE result first (a load's data is not there yet), then MEM.
   always_comb begin
      fwd_a_s = 2'd0;
      fwd_b_s = 2'd0;
      if (rs_exe_s && !bus.exe_is_load) begin
         fwd_a_s = 2'd1;
      end else if (rs_mem_s) begin
         fwd_a_s = 2'd2;
      end else begin
         fwd_a_s = 2'd0;
      end
      if (rt_exe_s && !bus.exe_is_load) begin
         fwd_b_s = 2'd1;
      end else if (rt_mem_s) begin
         fwd_b_s = 2'd2;
      end else begin
         fwd_b_s = 2'd0;
      end
   end

   // Pipe enables and bubbles: MDU stall beats load-use stall beats branch squash.
   always_comb begin
      pc_we_s      = 1'b1;
      ifid_we_s    = 1'b1;
      ifid_flush_s = 1'b0;
      idex_we_s    = 1'b1;
      idex_flush_s = 1'b0;
      exe_kill_s   = 1'b0;
      if (mdu_stall_s) begin
         // Whole front end frozen; ID/EXE is held rather than bubbled so the
         // instruction behind the MUL/DIV is not lost.
         pc_we_s    = 1'b0;
         ifid_we_s  = 1'b0;
         idex_we_s  = 1'b0;
         exe_kill_s = 1'b1;
      end else if (load_use_s) begin
         pc_we_s      = 1'b0;
         ifid_we_s    = 1'b0;
         idex_flush_s = 1'b1;
      end else begin
         // A taken branch held in ID by a stall is squashed once ID releases.
         ifid_flush_s = reset && bus.id_branch_taken && !DELAY_SLOT;
      end
   end

   // MUL/DIV sequencer: start cycle + (MDU_LATENCY-2) busy cycles, then one DONE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.exe_is_mdu) begin
                  cnt_r   <= CNT_INIT;
                  state_r <= (MDU_LATENCY <= 32'd2) ? ST_DONE : ST_BUSY;
               end else begin
                  cnt_r   <= cnt_r;
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_r <= CNT_ONE) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= ST_DONE;
               end else begin
                  cnt_r   <= cnt_r - CNT_ONE;
                  state_r <= ST_BUSY;
               end
            end
            ST_DONE: begin
               // exe_is_mdu is still high for the finishing instruction; ignore it.
               cnt_r   <= CNT_ZERO;
               state_r <= ST_IDLE;
            end
            default: begin
               cnt_r   <= CNT_ZERO;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_r <= 32'd0;
      end else if (!pc_we_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign bus.pc_we        = pc_we_s;
   assign bus.ifid_we      = ifid_we_s;
   assign bus.ifid_flush   = ifid_flush_s;
   assign bus.idex_we      = idex_we_s;
   assign bus.idex_flush   = idex_flush_s;
   assign bus.exe_kill     = exe_kill_s;
   assign bus.mdu_start    = mdu_start_s;
   assign bus.fwd_a_sel    = fwd_a_s;
   assign bus.fwd_b_sel    = fwd_b_s;
   assign bus.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench for pipe_hazard_ctrl (MDU_LATENCY=4, DELAY_SLOT=0).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exe_kill, mdu_start}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic clk;
   logic reset;
   int   vec_cnt;
   int   err_cnt;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(
      .MDU_LATENCY (4),
      .DELAY_SLOT  (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [6:0] ctl;
   assign ctl = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                 bus.idex_flush, bus.exe_kill, bus.mdu_start};

   localparam logic [6:0] CTL_RUN   = 7'b1101000;
   localparam logic [6:0] CTL_LDUSE = 7'b0001100;
   localparam logic [6:0] CTL_SQUASH = 7'b1111000;
   localparam logic [6:0] CTL_BUSY  = 7'b0000010;
   // Start cycle: exe_kill is left unchecked, everything else fixed.
   localparam logic [6:0] CTL_START = 7'b0000001;
   localparam logic [6:0] START_MSK = 7'b1111101;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one full set of status inputs.
   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic ewe, input logic [4:0] ewa,
                         input logic eld, input logic emdu,
                         input logic mwe, input logic [4:0] mwa);
      bus.id_rs_addr      = rs;
      bus.id_rt_addr      = rt;
      bus.id_uses_rs      = urs;
      bus.id_uses_rt      = urt;
      bus.id_branch_taken = br;
      bus.exe_rf_we       = ewe;
      bus.exe_rf_waddr    = ewa;
      bus.exe_is_load     = eld;
      bus.exe_is_mdu      = emdu;
      bus.mem_rf_we       = mwe;
      bus.mem_rf_waddr    = mwa;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
      @(negedge clk); #1;
      vec_cnt++;
      if (ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN);
      end
      vec_cnt++;
      if (bus.stall_cycles !== 32'd0) begin
         err_cnt++; $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cycles);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_load_use;
      // lw $2 in EXE, ID reads rs=$2
      @(negedge clk);
      set_in(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_LDUSE) begin
         err_cnt++; $display("FAIL load_use_rs_stall: got %b expected %b", ctl, CTL_LDUSE);
      end
      // load moved to MEM, bubble in EXE
      @(negedge clk);
      set_in(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2); #1;
      vec_cnt++;
      if (ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL load_use_release: got %b expected %b", ctl, CTL_RUN);
      end
      vec_cnt++;
      if (bus.fwd_a_sel !== 2'd2) begin
         err_cnt++; $display("FAIL load_use_fwd_a: got %0d expected 2", bus.fwd_a_sel);
      end
      vec_cnt++;
      if (bus.stall_cycles !== 32'd1) begin
         err_cnt++; $display("FAIL load_use_cnt: got %0d expected 1", bus.stall_cycles);
      end
      // lw $7 in EXE, ID reads rt=$7
      @(negedge clk);
      set_in(5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_LDUSE) begin
         err_cnt++; $display("FAIL load_use_rt_stall: got %b expected %b", ctl, CTL_LDUSE);
      end
      @(negedge clk);
      set_in(5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7); #1;
      vec_cnt++;
      if (bus.fwd_b_sel !== 2'd2 || ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL load_use_fwd_b: got sel %0d ctl %b expected sel 2 ctl %b",
                             bus.fwd_b_sel, ctl, CTL_RUN);
      end
   endtask

   task automatic test_fwd_priority;
      // add $3 in EXE and in MEM, ID reads rs=$3 and rt=$3
      @(negedge clk);
      set_in(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd3); #1;
      vec_cnt++;
      if (bus.fwd_a_sel !== 2'd1 || bus.fwd_b_sel !== 2'd1) begin
         err_cnt++; $display("FAIL fwd_exe_priority: got a=%0d b=%0d expected a=1 b=1",
                             bus.fwd_a_sel, bus.fwd_b_sel);
      end
      vec_cnt++;
      if (ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL fwd_no_stall: got %b expected %b", ctl, CTL_RUN);
      end
      // EXE writes $4, MEM writes $3; rs=$3 from MEM, rt=$4 from EXE
      @(negedge clk);
      set_in(5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 5'd3); #1;
      vec_cnt++;
      if (bus.fwd_a_sel !== 2'd2 || bus.fwd_b_sel !== 2'd1) begin
         err_cnt++; $display("FAIL fwd_mixed: got a=%0d b=%0d expected a=2 b=1",
                             bus.fwd_a_sel, bus.fwd_b_sel);
      end
      // same addresses but ID does not read the operands
      @(negedge clk);
      set_in(5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 5'd3); #1;
      vec_cnt++;
      if (bus.fwd_a_sel !== 2'd0 || bus.fwd_b_sel !== 2'd0) begin
         err_cnt++; $display("FAIL fwd_unused: got a=%0d b=%0d expected a=0 b=0",
                             bus.fwd_a_sel, bus.fwd_b_sel);
      end
   endtask

   task automatic test_zero_reg;
      // load to $0 in EXE, write to $0 in MEM, ID reads $0 on both ports
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0); #1;
      vec_cnt++;
      if (bus.fwd_a_sel !== 2'd0 || bus.fwd_b_sel !== 2'd0 || ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL zero_reg: got a=%0d b=%0d ctl %b expected a=0 b=0 ctl %b",
                             bus.fwd_a_sel, bus.fwd_b_sel, ctl, CTL_RUN);
      end
   endtask

   task automatic test_branch;
      // plain taken branch, no hazard: squash IF/ID
      @(negedge clk);
      set_in(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_SQUASH) begin
         err_cnt++; $display("FAIL branch_squash: got %b expected %b", ctl, CTL_SQUASH);
      end
      // taken branch + load-use on rs=$5: stall wins
      @(negedge clk);
      set_in(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_LDUSE) begin
         err_cnt++; $display("FAIL branch_vs_load_use: got %b expected %b", ctl, CTL_LDUSE);
      end
      // ID released: branch re-evaluated and squashes
      @(negedge clk);
      set_in(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5); #1;
      vec_cnt++;
      if (ctl !== CTL_SQUASH || bus.fwd_a_sel !== 2'd2) begin
         err_cnt++; $display("FAIL branch_after_stall: got ctl %b a=%0d expected ctl %b a=2",
                             ctl, bus.fwd_a_sel, CTL_SQUASH);
      end
      vec_cnt++;
      if (bus.stall_cycles !== 32'd3) begin
         err_cnt++; $display("FAIL branch_cnt: got %0d expected 3", bus.stall_cycles);
      end
   endtask

   task automatic test_mdu;
      // MUL in EXE (also flagged as load-use against ID to prove the bubble is suppressed)
      @(negedge clk);
      set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0); #1;
      vec_cnt++;
      if ((ctl & START_MSK) !== CTL_START) begin
         err_cnt++; $display("FAIL mdu_start_cycle: got %b expected %b (mask %b)",
                             ctl, CTL_START, START_MSK);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         vec_cnt++;
         if (ctl !== CTL_BUSY) begin
            err_cnt++; $display("FAIL mdu_busy_%0d: got %b expected %b", i, ctl, CTL_BUSY);
         end
      end
      // DONE: exe_is_mdu still high but must not retrigger
      @(negedge clk);
      set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_RUN) begin
         err_cnt++; $display("FAIL mdu_done: got %b expected %b", ctl, CTL_RUN);
      end
      vec_cnt++;
      if (bus.stall_cycles !== 32'd6) begin
         err_cnt++; $display("FAIL mdu_cnt: got %0d expected 6", bus.stall_cycles);
      end
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0); #1;
      vec_cnt++;
      if (ctl !== CTL_RUN || bus.stall_cycles !== 32'd6) begin
         err_cnt++; $display("FAIL mdu_idle_after: got ctl %b cnt %0d expected ctl %b cnt 6",
                             ctl, bus.stall_cycles, CTL_RUN);
      end
   endtask

   task automatic test_reset_mid_mdu;
      @(negedge clk);
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
      @(negedge clk); #1;
      vec_cnt++;
      if (ctl !== CTL_BUSY) begin
         err_cnt++; $display("FAIL rst_mdu_busy1: got %b expected %b", ctl, CTL_BUSY);
      end
      @(negedge clk); #1;
      vec_cnt++;
      if (ctl !== CTL_BUSY) begin
         err_cnt++; $display("FAIL rst_mdu_busy2: got %b expected %b", ctl, CTL_BUSY);
      end
      reset = 1'b0; #1;
      vec_cnt++;
      if (ctl !== CTL_RUN || bus.stall_cycles !== 32'd0) begin
         err_cnt++; $display("FAIL rst_mdu_release: got ctl %b cnt %0d expected ctl %b cnt 0",
                             ctl, bus.stall_cycles, CTL_RUN);
      end
      @(negedge clk);
      bus.exe_is_mdu = 1'b0;
      reset = 1'b1; #1;
      for (int i = 0; i < 2; i++) begin
         vec_cnt++;
         if (ctl !== CTL_RUN || bus.stall_cycles !== 32'd0) begin
            err_cnt++; $display("FAIL rst_mdu_after_%0d: got ctl %b cnt %0d expected ctl %b cnt 0",
                                i, ctl, bus.stall_cycles, CTL_RUN);
         end
         @(negedge clk); #1;
      end
   endtask

   // Bound the run in case the clocking ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_zero_reg();
      test_branch();
      test_mdu();
      test_reset_mid_mdu();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
